// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the fetch stage: boolean levels, bus width and FSM encoding.
package fetch_queue_unit_pkg;

  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam int   DATA_BUS_W = 32;

  // IDLE: nothing outstanding, WAIT: one read outstanding,
  // DROP: one read outstanding whose data will be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_unit_queue.sv
// Circular instruction FIFO. Storage is not reset; only pointers and the
// occupancy counter are. Pop on empty and push on full (without a pop) are ignored.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: keeps one ICache read in flight, follows the branch
// predictor's next PC and buffers fetched instructions for the decoder.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN     = DATA_BUS_W,
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 18,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   clr,
  input  logic [XLEN-1:0]        target_pc,
  output logic [XLEN-1:0]        bp_query_pc,
  input  logic [XLEN-1:0]        bp_next_pc,
  input  logic                   bp_taken,
  output logic                   ic_rn,
  output logic [ADDR_W-1:0]      ic_addr,
  input  logic [XLEN-1:0]        ic_inst,
  input  logic                   ic_read_ready,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_pred_pc,
  output logic                   out_pred_taken,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int ENTRY_W = 3 * XLEN + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic             issue;
  logic             accept;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pend_pc;
  logic [XLEN-1:0]  pend_pred;
  logic             pend_taken;
  logic             q_push;
  logic             q_pop;
  logic             q_flush;
  logic             q_empty;
  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W-1:0] q_count;

  // Next state and issue/accept decisions. IDLE means nothing is in flight, so
  // count < DEPTH is exactly the slot reservation for the new request.
  always_comb begin
    state_nxt = state;
    issue     = FALSE;
    accept    = FALSE;
    case (state)
      IDLE: begin
        if (!clr && (q_count < FULL)) begin
          issue     = TRUE;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (clr) begin
          state_nxt = ic_read_ready ? IDLE : DROP;
        end else if (ic_read_ready) begin
          accept    = TRUE;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (ic_read_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register; rdy low freezes it.
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // Fetch PC and ICache request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      ic_rn    <= FALSE;
      ic_addr  <= '0;
    end else if (rdy) begin
      if (clr)        fetch_pc <= target_pc;
      else if (issue) fetch_pc <= bp_next_pc;
      if (issue) begin
        ic_rn   <= TRUE;
        ic_addr <= fetch_pc[ADDR_W-1:0];
      end else if (ic_read_ready && (state != IDLE)) begin
        ic_rn   <= FALSE;
      end
    end
  end

  // Prediction captured alongside the outstanding request.
  always_ff @(posedge clk) begin
    if (rdy && issue) begin
      pend_pc    <= fetch_pc;
      pend_pred  <= bp_next_pc;
      pend_taken <= bp_taken;
    end
  end

  assign bp_query_pc = fetch_pc;

  // A flush wins over both the push of a same-cycle response and a same-cycle pop.
  assign q_push  = rdy && accept;
  assign q_pop   = rdy && !clr && out_ready && !q_empty;
  assign q_flush = rdy && clr;

  inst_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({ic_inst, pend_pc, pend_pred, pend_taken}),
    .pop       (q_pop),
    .flush     (q_flush),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign {out_inst, out_pc, out_pred_pc, out_pred_taken} = q_head;
  assign out_valid   = !q_empty;
  assign queue_count = q_count;

  // The ICache must never answer while no request is outstanding.
  a_no_idle_response: assert property (@(posedge clk) disable iff (rst)
    !(rdy && ic_read_ready && (state == IDLE)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: behavioural ICache/predictor plus a queue-based
// reference of the expected fetch stream and instruction buffer.
module tb_fetch_queue_unit;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, rdy = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [XLEN-1:0]   target_pc = '0;
  logic [XLEN-1:0]   bp_query_pc, bp_next_pc;
  logic              bp_taken;
  logic              ic_rn;
  logic [ADDR_W-1:0] ic_addr;
  logic [XLEN-1:0]   ic_inst = '0;
  logic              ic_read_ready = 1'b0;
  logic              out_valid, out_pred_taken;
  logic [XLEN-1:0]   out_inst, out_pc, out_pred_pc;
  logic [2:0]        queue_count;

  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .target_pc(target_pc),
    .bp_query_pc(bp_query_pc), .bp_next_pc(bp_next_pc), .bp_taken(bp_taken),
    .ic_rn(ic_rn), .ic_addr(ic_addr), .ic_inst(ic_inst), .ic_read_ready(ic_read_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_pred_pc(out_pred_pc),
    .out_pred_taken(out_pred_taken), .out_ready(out_ready), .queue_count(queue_count)
  );

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred;
    logic            taken;
  } ent_t;

  int checks = 0, errors = 0;
  ent_t mq[$];
  logic [XLEN-1:0] issued[$];
  logic [XLEN-1:0] popped[$];
  logic [XLEN-1:0] exp_pc = '0;
  int nreq = 0;

  // predictor configuration: 0 sequential, 1 single override, 2 hashed taken branches
  int pred_mode = 0;
  logic [XLEN-1:0] ov_src = '0, ov_tgt = '0;

  // ICache model state
  bit ic_busy = 0, ic_drop = 0, rand_lat = 0, stall_tog = 0;
  int ic_cnt = 0, lat = 1;
  logic [XLEN-1:0] ic_req_pc = '0, ic_req_pred = '0;
  logic ic_req_taken = 1'b0;

  function automatic logic [XLEN-1:0] pred_of(input logic [XLEN-1:0] pc);
    if (pred_mode == 1 && pc == ov_src) return ov_tgt;
    if (pred_mode == 2 && pc[4:2] == 3'b101) return pc + 32'h20;
    return pc + 32'd4;
  endfunction

  function automatic logic taken_of(input logic [XLEN-1:0] pc);
    return (pred_mode == 1 && pc == ov_src) || (pred_mode == 2 && pc[4:2] == 3'b101);
  endfunction

  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1234_0000;
  endfunction

  always_comb begin
    bp_next_pc = bp_query_pc + 32'd4;
    bp_taken   = 1'b0;
    if (pred_mode == 1 && bp_query_pc == ov_src) begin
      bp_next_pc = ov_tgt;
      bp_taken   = 1'b1;
    end else if (pred_mode == 2 && bp_query_pc[4:2] == 3'b101) begin
      bp_next_pc = bp_query_pc + 32'h20;
      bp_taken   = 1'b1;
    end
  end

  // One clock cycle: drive ICache response, advance the reference, check the DUT.
  task automatic tick();
    bit do_pop, retire;
    logic [ADDR_W-1:0] want_addr;
    ic_read_ready = 1'b0;
    if (ic_busy && ic_cnt == 0) begin
      ic_inst = inst_of(ic_req_pc);
      ic_read_ready = rdy ? 1'b1 : stall_tog;
      stall_tog = ~stall_tog;
    end
    do_pop = rdy && !clr && out_ready && (mq.size() != 0) && !rst;
    if (do_pop) popped.push_back(out_pc);
    retire = rdy && ic_read_ready && !rst;
    @(posedge clk); #1;
    ic_read_ready = 1'b0;
    if (rst) begin
      mq.delete(); exp_pc = '0; ic_busy = 0; ic_drop = 0;
    end else if (rdy) begin
      if (clr) begin
        mq.delete(); exp_pc = target_pc;
        if (ic_busy && !retire) ic_drop = 1;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (retire && !ic_drop) mq.push_back('{inst_of(ic_req_pc), ic_req_pc, ic_req_pred, ic_req_taken});
      end
      if (retire) begin ic_busy = 0; ic_drop = 0; end
      else if (ic_busy && ic_cnt > 0) ic_cnt--;
    end
    if (!rst && ic_rn && !ic_busy) begin
      want_addr = exp_pc[ADDR_W-1:0];
      checks++;
      if (ic_addr !== want_addr) begin
        errors++; $display("FAIL req_addr: got %h want %h", ic_addr, want_addr);
      end
      checks++;
      if (mq.size() + 1 > DEPTH) begin
        errors++; $display("FAIL reservation: issued with %0d queued", mq.size());
      end
      issued.push_back({{(XLEN-ADDR_W){1'b0}}, ic_addr});
      ic_busy = 1; ic_drop = 0;
      ic_cnt = rand_lat ? int'($urandom_range(3, 0)) : lat - 1;
      ic_req_pc = exp_pc; ic_req_pred = pred_of(exp_pc); ic_req_taken = taken_of(exp_pc);
      exp_pc = ic_req_pred;
      nreq++;
    end
    checks++;
    if (int'(queue_count) !== mq.size()) begin
      errors++; $display("FAIL count: got %0d want %0d", queue_count, mq.size());
    end
    checks++;
    if (out_valid !== (mq.size() != 0)) begin
      errors++; $display("FAIL out_valid: got %b want %b", out_valid, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      checks++;
      if ({out_inst, out_pc, out_pred_pc, out_pred_taken} !== mq[0]) begin
        errors++;
        $display("FAIL head: got pc=%h inst=%h pred=%h tk=%b want pc=%h inst=%h pred=%h tk=%b",
                 out_pc, out_inst, out_pred_pc, out_pred_taken, mq[0].pc, mq[0].inst, mq[0].pred, mq[0].taken);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; rdy = 0; clr = 1; target_pc = 32'h0000_0abc; out_ready = 0;
    tick(); tick();
    rdy = 1; tick();
    clr = 0; tick();
    checks++; if (ic_rn !== 1'b0) begin errors++; $display("FAIL rst_ic_rn: got %b want 0", ic_rn); end
    checks++; if (ic_addr !== '0) begin errors++; $display("FAIL rst_ic_addr: got %h want 0", ic_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", queue_count); end
    checks++; if (bp_query_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bp_query_pc); end
    rst = 0;
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] want;
    lat = 1; out_ready = 1; pred_mode = 0;
    issued.delete(); popped.delete();
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin
      want = 32'(4 * i);
      checks++;
      if (issued.size() <= i || issued[i] !== want) begin
        errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, issued.size() > i ? issued[i] : 32'hx, want);
      end
      checks++;
      if (popped.size() <= i || popped[i] !== want) begin
        errors++; $display("FAIL seq_pop[%0d]: got %h want %h", i, popped.size() > i ? popped[i] : 32'hx, want);
      end
    end
  endtask

  task automatic test_full();
    int n0;
    out_ready = 0; lat = 1;
    clr = 1; target_pc = 32'h200; tick(); clr = 0;
    n0 = nreq;
    repeat (30) tick();
    checks++; if (nreq - n0 != DEPTH) begin errors++; $display("FAIL full_reqs: got %0d want %0d", nreq - n0, DEPTH); end
    checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", queue_count); end
    checks++; if (ic_rn !== 1'b0) begin errors++; $display("FAIL full_ic_rn: got %b want 0", ic_rn); end
    out_ready = 1; tick(); out_ready = 0;
    repeat (10) tick();
    checks++; if (nreq - n0 != DEPTH + 1) begin errors++; $display("FAIL refill_reqs: got %0d want %0d", nreq - n0, DEPTH + 1); end
    checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL refill_count: got %0d want 4", queue_count); end
  endtask

  task automatic test_predict();
    int k0;
    pred_mode = 1; ov_src = 32'h10; ov_tgt = 32'h40; out_ready = 0;
    k0 = issued.size();
    clr = 1; target_pc = 32'h10; tick(); clr = 0;
    repeat (10) tick();
    checks++; if (issued.size() < k0 + 2 || issued[k0] !== 32'h10) begin errors++; $display("FAIL pred_first: got %h want 00000010", issued.size() > k0 ? issued[k0] : 32'hx); end
    checks++; if (issued.size() < k0 + 2 || issued[k0+1] !== 32'h40) begin errors++; $display("FAIL pred_next: got %h want 00000040", issued.size() > k0 + 1 ? issued[k0+1] : 32'hx); end
    checks++; if (out_pc !== 32'h10 || out_pred_pc !== 32'h40 || out_pred_taken !== 1'b1) begin
      errors++; $display("FAIL pred_head: got pc=%h pred=%h tk=%b want 10/40/1", out_pc, out_pred_pc, out_pred_taken);
    end
    pred_mode = 0;
  endtask

  task automatic test_flush_wait();
    int k0, p0, i;
    out_ready = 1; lat = 3;
    for (i = 0; i < 60 && !(ic_busy && !ic_drop && ic_cnt == 2); i++) tick();
    checks++; if (!(ic_busy && ic_cnt == 2)) begin errors++; $display("FAIL fw_timeout: got busy=%0d want busy=1", ic_busy); end
    k0 = issued.size(); p0 = popped.size();
    clr = 1; target_pc = 32'h100; tick(); clr = 0;
    for (i = 0; i < 20 && ic_busy; i++) tick();
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL fw_dropped: got count %0d want 0", queue_count); end
    repeat (20) tick();
    checks++; if (issued.size() <= k0 || issued[k0] !== 32'h100) begin errors++; $display("FAIL fw_addr: got %h want 00000100", issued.size() > k0 ? issued[k0] : 32'hx); end
    checks++; if (popped.size() <= p0 || popped[p0] !== 32'h100) begin errors++; $display("FAIL fw_pop: got %h want 00000100", popped.size() > p0 ? popped[p0] : 32'hx); end
  endtask

  task automatic test_flush_resp();
    int k0, i;
    out_ready = 0; lat = 1;
    clr = 1; target_pc = 32'h300; tick(); clr = 0;
    for (i = 0; i < 60 && !(mq.size() == 3 && ic_busy && !ic_drop && ic_cnt == 0); i++) tick();
    checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL fr_setup: got count %0d want 3", queue_count); end
    k0 = issued.size();
    clr = 1; target_pc = 32'h500; tick(); clr = 0;
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL fr_count: got %0d want 0", queue_count); end
    checks++; if (ic_rn !== 1'b0) begin errors++; $display("FAIL fr_idle: got ic_rn %b want 0", ic_rn); end
    tick();
    checks++; if (issued.size() != k0 + 1 || issued[k0] !== 32'h500) begin errors++; $display("FAIL fr_addr: got %h want 00000500", issued.size() > k0 ? issued[k0] : 32'hx); end
  endtask

  task automatic test_rdy_stall();
    int i;
    out_ready = 0; lat = 2;
    clr = 1; target_pc = 32'h600; tick(); clr = 0;
    for (i = 0; i < 60 && !(ic_busy && !ic_drop && ic_cnt == 0 && mq.size() == 0); i++) tick();
    checks++; if (!(ic_busy && ic_req_pc == 32'h600)) begin errors++; $display("FAIL st_setup: got busy=%0d want 1", ic_busy); end
    rdy = 0;
    repeat (5) tick();
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL st_frozen_count: got %0d want 0", queue_count); end
    checks++; if (ic_rn !== 1'b1) begin errors++; $display("FAIL st_frozen_rn: got %b want 1", ic_rn); end
    rdy = 1; tick();
    checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL st_accept: got %0d want 1", queue_count); end
    checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL st_head: got %h want 00000600", out_pc); end
  endtask

  task automatic test_random();
    rand_lat = 1; pred_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      out_ready = 1'($urandom_range(1, 0));
      rdy       = ($urandom_range(9, 0) != 0);
      clr       = ($urandom_range(39, 0) == 0);
      target_pc = 32'($urandom_range(4095, 0)) << 2;
      tick();
    end
    clr = 0; rdy = 1; rand_lat = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_predict();
    test_flush_wait();
    test_flush_resp();
    test_rdy_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction fetch stage with a parametrised instruction queue between the ICache and the decoder.
- Keeps one ICache read outstanding and follows the branch predictor's next PC.
- Buffers up to DEPTH fetched instructions together with their PC and prediction.
- On a pipeline flush, redirects to the target PC and discards any response still in flight.

Parameters:
- XLEN, 32: instruction/PC width.
- DEPTH, 4: queue entries; power of two, >= 2.
- ADDR_W, 18: ICache address bits driven (PC[ADDR_W-1:0]).
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low all state freezes
- clr  in  1  flush/redirect from flow controller
- target_pc  in  XLEN  redirect PC, valid with clr
- bp_query_pc  out  XLEN  PC of the request being issued (combinational = fetch_pc)
- bp_next_pc  in  XLEN  predicted next PC for bp_query_pc (combinational)
- bp_taken  in  1  prediction taken flag for bp_query_pc
- ic_rn  out  1  ICache read request
- ic_addr  out  ADDR_W  ICache read address
- ic_inst  in  XLEN  ICache read data
- ic_read_ready  in  1  ic_inst valid this cycle; one pulse per request
- out_valid  out  1  queue head valid
- out_inst  out  XLEN  head instruction
- out_pc  out  XLEN  head PC
- out_pred_pc  out  XLEN  head predicted next PC
- out_pred_taken  out  1  head prediction flag
- out_ready  in  1  decoder pops head when out_valid && out_ready && rdy
- queue_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst high at posedge):
  - fetch_pc=RESET_PC; queue empty; state=IDLE.
  - ic_rn=0; ic_addr=0; out_valid=0; queue_count=0.
  - rst has priority over clr and rdy.
- rdy low: no state, pointer or output register changes. ic_read_ready and out_ready are ignored.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding whose response must be discarded.
- IDLE -> WAIT: when queue_count < DEPTH and clr=0.
  - Register ic_rn=1 and ic_addr=fetch_pc.
  - Latch pend_pc=fetch_pc, pend_pred=bp_next_pc, pend_taken=bp_taken.
  - fetch_pc <= bp_next_pc.
- WAIT, ic_read_ready=1:
  - Push {ic_inst, pend_pc, pend_pred, pend_taken}; ic_rn<=0.
  - Next cycle: IDLE, or straight to a new issue (WAIT) if the reservation rule allows.
  - Back-to-back throughput: one instruction per ICache latency + 1.
- Slot reservation: an issue requires count + 1 <= DEPTH, counting the in-flight entry. A response therefore never finds the queue full. A push with a same-cycle pop is legal at any occupancy.
- DROP, ic_read_ready=1: response discarded; ic_rn<=0; -> IDLE.
- clr=1 (any state):
  - Queue emptied (pointers and count reset); out_valid=0 next cycle; fetch_pc<=target_pc.
  - A same-cycle pop is ignored.
  - A same-cycle response is discarded.
  - State transitions:
    - IDLE: -> IDLE.
    - WAIT without ic_read_ready: -> DROP.
    - WAIT with ic_read_ready: -> IDLE.
    - DROP without ic_read_ready: stays DROP.
  - First redirected request issues at the earliest the cycle after clr, from IDLE.
- Pop: head pointer advances and count decrements. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Outputs out_* are the registered head entry. out_valid = (count != 0).
- queue_count never exceeds DEPTH. An ic_read_ready in IDLE is ignored (protocol error, asserted in sim).

Decomposition:
- Shared constants header:
  - True/False, Data_Bus width macro.
  - State encodings IDLE=2'd0, WAIT=2'd1, DROP=2'd2.
- Sub-module inst_queue: circular FIFO, parameters DEPTH/WIDTH.
  - Ports: push, push_data, pop, flush, head_data, count, empty.
  - Entry width 2*XLEN+XLEN+1.
- Fetch FSM, PC register and predictor interface stay in fetch_queue_unit.

Test Plan:
- Reset, ICache latency 1, bp_next_pc=pc+4, out_ready=1 -> addresses 0x0,0x4,0x8 issued; out_pc sequence 0,4,8 with matching out_inst.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued, then ic_rn stays 0, queue_count=4. Single pop -> one new request issued, and count returns to 4 after its response.
- bp_query_pc=0x10 with bp_next_pc=0x40, bp_taken=1 -> next ic_addr=0x40; entry for 0x10 pops with out_pred_pc=0x40, out_pred_taken=1.
- clr with target_pc=0x100 while WAIT, response 2 cycles later -> response dropped, queue empty; next issued ic_addr=0x100; first popped out_pc=0x100.
- clr in the same cycle as ic_read_ready with queue holding 3 entries -> nothing pushed, count=0 next cycle, state IDLE, then issue at target_pc.
- rdy low for 5 cycles mid-WAIT with ic_read_ready pulsed -> no push, pointers/outputs unchanged. After rdy returns high, the response is delivered again and accepted normally.
